// File: rtl/barcode_rx.sv
// barcode_rx: decodes the serial station barcode into an 8-bit station ID.
//
// A frame is a start bar followed by 8 data bars, sent MSB first. The low
// width of the start bar sets the sample point for every data bar. A data bar
// that is still low at that point decodes as 0 (long bar). A data bar that has
// already gone high decodes as 1 (short bar). Only IDs with ID[7:6]==2'b00 are
// presented to the consumer.
//
// Ports:
//   clk        - system clock
//   rst_n      - synchronous active-low reset
//   BC         - raw barcode line, asynchronous, idles high
//   clr_ID_vld - one-cycle consumer pulse that clears ID_vld
//   ID         - last valid station ID
//   ID_vld     - high while ID holds an unconsumed valid ID
module barcode_rx #(
    parameter int CNT_W = 22
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       BC,
    input  logic       clr_ID_vld,
    output logic [7:0] ID,
    output logic       ID_vld
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_FALL,
        TIME_BIT,
        DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] timer;
    logic [7:0]       shift;
    logic [3:0]       bit_cnt;

    // Two-flop synchronizer plus one edge flop. All three reset high, which
    // matches the idle level, so reset can never create a false fall.
    logic sync1_q, sync_q, edge_q;
    logic bc_s, fall;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_q <= 1'b1;
            sync_q  <= 1'b1;
            edge_q  <= 1'b1;
        end else begin
            sync1_q <= BC;
            sync_q  <= sync1_q;
            edge_q  <= sync_q;
        end
    end

    assign bc_s = sync_q;
    assign fall = edge_q & ~sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            period  <= '0;
            timer   <= '0;
            shift   <= 8'h00;
            bit_cnt <= 4'd0;
            ID      <= 8'h00;
            ID_vld  <= 1'b0;
        end else begin
            // A clear can be overridden by a set later in this block.
            // If both happen in the same cycle, the new ID is kept.
            if (clr_ID_vld)
                ID_vld <= 1'b0;

            case (state)
                IDLE: begin
                    if (fall) begin
                        period  <= '0;
                        bit_cnt <= 4'd0;
                        state   <= START;
                    end
                end

                // The cycle that detected the fall is already one low cycle.
                // As a result, period ends one less than the bar width. That
                // offset is matched in TIME_BIT, which also starts one cycle
                // after its own fall.
                START: begin
                    if (bc_s) begin
                        timer <= '0;
                        state <= WAIT_FALL;
                    end else if (period == CNT_MAX) begin
                        state <= IDLE;
                    end else begin
                        period <= period + 1'b1;
                    end
                end

                WAIT_FALL: begin
                    if (fall) begin
                        timer <= '0;
                        state <= TIME_BIT;
                    end else if (timer == CNT_MAX) begin
                        state <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end

                TIME_BIT: begin
                    if (timer != CNT_MAX)
                        timer <= timer + 1'b1;
                    if (timer == period) begin
                        shift   <= {shift[6:0], bc_s};
                        bit_cnt <= bit_cnt + 1'b1;
                        timer   <= '0;
                        state   <= (bit_cnt == 4'd7) ? DONE : WAIT_FALL;
                    end
                end

                DONE: begin
                    if (shift[7:6] == 2'b00) begin
                        ID     <= shift;
                        ID_vld <= 1'b1;
                    end
                    state <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_barcode_rx.sv
// Directed bench for barcode_rx with a scoreboard of expected IDs.
// The small CNT_W keeps the abort timeout short.
module tb_barcode_rx;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       bc;
    logic       clr;
    logic [7:0] id;
    logic       id_vld;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_q[$];
    logic       prev_vld = 1'b0;
    logic [7:0] prev_id  = 8'h00;

    barcode_rx #(.CNT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .BC         (bc),
        .clr_ID_vld (clr),
        .ID         (id),
        .ID_vld     (id_vld)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumer: each newly presented ID must match the oldest
    // expected ID in the queue.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && id_vld === 1'b1 && (!prev_vld || id !== prev_id)) begin
            if (exp_q.size() == 0) begin
                check("unexpected_id", id, 8'hxx);
            end else begin
                check("scoreboard_id", id, exp_q.pop_front());
            end
        end
        prev_vld = id_vld;
        prev_id  = id;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_bar(input int w);
        for (int c = 0; c < 200; c++) begin
            bc = (c < w) ? 1'b0 : 1'b1;
            @(posedge clk);
            #1;
        end
    endtask

    // Data bars first..last (0 is the MSB), 200-clock pitch. If clr_done is
    // set, a clr pulse lands on the DONE cycle of bar 7. That cycle is
    // 103 clocks after the bar drops, given a 100-clock start bar.
    task automatic send_bars(input logic [7:0] val, input int first, input int last,
                             input bit clr_done);
        for (int i = first; i <= last; i++) begin
            logic [7:0] v;
            int w;
            v = val;
            w = v[7-i] ? 50 : 150;
            for (int c = 0; c < 200; c++) begin
                bc  = (c < w) ? 1'b0 : 1'b1;
                clr = (clr_done && i == 7 && c == 103) ? 1'b1 : 1'b0;
                @(posedge clk);
                #1;
            end
        end
        bc  = 1'b1;
        clr = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] val, input bit clr_done);
        if (val[7:6] == 2'b00)
            exp_q.push_back(val);
        start_bar(100);
        send_bars(val, 0, 7, clr_done);
        idle(20);
    endtask

    task automatic pulse_clr;
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        bc    = 1'b1;
        clr   = 1'b0;
        idle(2);
        rst_n = 1'b1;

        // Reset state holds while the line idles.
        for (int i = 0; i < 50; i++) begin
            check("reset_id", id, 8'h00);
            check("reset_vld", {7'd0, id_vld}, 8'h01 & 8'h00);
            idle(1);
        end

        // Valid frame.
        send_frame(8'h0A, 1'b0);
        idle(100);
        check("frame_0a_id", id, 8'h0A);
        check("frame_0a_vld", {7'd0, id_vld}, 8'h01);

        // Handshake clear.
        pulse_clr();
        check("clr_vld", {7'd0, id_vld}, 8'h00);
        check("clr_id_hold", id, 8'h0A);

        // A set on DONE wins over a clr in the same cycle.
        send_frame(8'h15, 1'b1);
        check("coincide_vld", {7'd0, id_vld}, 8'h01);
        check("coincide_id", id, 8'h15);

        // An invalid frame is discarded.
        pulse_clr();
        check("pre_invalid_vld", {7'd0, id_vld}, 8'h00);
        send_frame(8'hC5, 1'b0);
        idle(50);
        check("invalid_vld", {7'd0, id_vld}, 8'h00);
        check("invalid_id", id, 8'h15);

        // Abort: a short start bar followed by no data times out.
        start_bar(20);
        idle(300);
        check("abort_vld", {7'd0, id_vld}, 8'h00);
        check("abort_id", id, 8'h15);
        send_frame(8'h3F, 1'b0);
        check("post_abort_id", id, 8'h3F);
        check("post_abort_vld", {7'd0, id_vld}, 8'h01);

        // Mid-frame reset. The leftover bars cannot form a full frame and
        // time out while the line idles.
        start_bar(100);
        send_bars(8'h2A, 0, 2, 1'b0);
        rst_n = 1'b0;
        idle(1);
        check("midrst_id", id, 8'h00);
        check("midrst_vld", {7'd0, id_vld}, 8'h00);
        rst_n = 1'b1;
        send_bars(8'h2A, 3, 7, 1'b0);
        idle(400);
        check("leftover_id", id, 8'h00);
        check("leftover_vld", {7'd0, id_vld}, 8'h00);
        send_frame(8'h2A, 1'b0);
        check("fresh_id", id, 8'h2A);
        check("fresh_vld", {7'd0, id_vld}, 8'h01);

        check("scoreboard_drained", 8'(exp_q.size()), 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
